// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU op encodings and divider state type
package mdu_pkg;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
endpackage

// File: rtl/mdu_mresult_if.sv
// mdu_mresult_if: pipeline-side bundle of the MDU M-stage result unit
interface mdu_mresult_if #(parameter int XLEN = 64);
    logic              StallM, FlushE, StallW, FlushW;
    logic [XLEN-1:0]   ForwardedSrcAE, ForwardedSrcBE;
    logic              IntDivE, W64E, W64M;
    logic [2:0]        Funct3E, Funct3M;
    logic [2*XLEN-1:0] ProdM;
    logic              DivBusyE;
    logic [XLEN-1:0]   MDUResultW;
    modport master (
        output StallM, FlushE, StallW, FlushW, ForwardedSrcAE, ForwardedSrcBE,
               IntDivE, W64E, W64M, Funct3E, Funct3M, ProdM,
        input  DivBusyE, MDUResultW
    );
    modport slave (
        input  StallM, FlushE, StallW, FlushW, ForwardedSrcAE, ForwardedSrcBE,
               IntDivE, W64E, W64M, Funct3E, Funct3M, ProdM,
        output DivBusyE, MDUResultW
    );
endinterface

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: radix-2 restoring divider, one quotient bit per cycle, signs fixed up at the end
module mdu_div_iter import mdu_pkg::*; #(parameter int XLEN = 64) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic            w64_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic            stall_i,
    output logic            busy_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);
    localparam int CW = $clog2(XLEN + 1);
    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, r_q, r_d, quot_q, quot_d, rem_q, rem_d;
    logic            negq_q, negq_d, negr_q, negr_d;
    logic [XLEN-1:0] ax, bx, am, bm, a_nx, r_nx;
    logic            sa, sb, qbit;
    logic [XLEN:0]   rs, diff;
    // operand extension, magnitudes and one restoring step from the current partial remainder
    always_comb begin
        ax   = w64_i ? (signed_i ? XLEN'($signed(a_i[31:0])) : XLEN'(a_i[31:0])) : a_i;
        bx   = w64_i ? (signed_i ? XLEN'($signed(b_i[31:0])) : XLEN'(b_i[31:0])) : b_i;
        sa   = signed_i & ax[XLEN-1];
        sb   = signed_i & bx[XLEN-1];
        am   = sa ? -ax : ax;
        bm   = sb ? -bx : bx;
        rs   = {r_q, a_q[XLEN-1]};
        diff = rs - {1'b0, b_q};
        qbit = ~diff[XLEN];
        r_nx = qbit ? diff[XLEN-1:0] : rs[XLEN-1:0];
        a_nx = {a_q[XLEN-2:0], qbit};
    end
    // FSM next state; W-form dividends are pre-shifted so only 32 steps are needed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_o  = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                busy_o = start_i;
                if (start_i && !flush_i) begin
                    negq_d  = sa ^ sb;
                    negr_d  = sa;
                    a_d     = w64_i ? am << (XLEN - 32) : am;
                    b_d     = bm;
                    r_d     = '0;
                    cnt_d   = w64_i ? CW'(32) : CW'(XLEN);
                    state_d = (bx == '0) ? DIV_DONE : DIV_BUSY;
                    quot_d  = (bx == '0) ? '1 : quot_q;
                    rem_d   = (bx == '0) ? ax : rem_q;
                end
            end
            DIV_BUSY: begin
                busy_o = 1'b1;
                a_d    = a_nx;
                r_d    = r_nx;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DIV_DONE;
                    quot_d  = negq_q ? -a_nx : a_nx;
                    rem_d   = negr_q ? -r_nx : r_nx;
                end
            end
            DIV_DONE: state_d = stall_i ? DIV_DONE : DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush_i) begin
            state_d = DIV_IDLE;
            quot_d  = quot_q;
            rem_d   = rem_q;
        end
    end
    // divider state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end
    assign quot_o = quot_q;
    assign rem_o  = rem_q;
endmodule

// File: rtl/mdu_mresult.sv
// mdu_mresult: MDU M-stage result select (product/quotient/remainder) registered into W
module mdu_mresult import mdu_pkg::*; #(parameter int XLEN = 64) (
    input logic          clk,
    input logic          reset,
    mdu_mresult_if.slave bus
);
    logic [XLEN-1:0] quot, rem, sel, res_d, res_q;
    mdu_div_iter #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start_i  (bus.IntDivE),
        .signed_i (~bus.Funct3E[0]),
        .w64_i    (bus.W64E),
        .a_i      (bus.ForwardedSrcAE),
        .b_i      (bus.ForwardedSrcBE),
        .flush_i  (bus.FlushE),
        .stall_i  (bus.StallM),
        .busy_o   (bus.DivBusyE),
        .quot_o   (quot),
        .rem_o    (rem)
    );
    // pick the op result and sign-extend the low word for W-forms
    always_comb begin
        sel   = (bus.Funct3M == F3_MUL) ? bus.ProdM[XLEN-1:0] :
                !bus.Funct3M[2] ? bus.ProdM[2*XLEN-1:XLEN] :
                !bus.Funct3M[1] ? quot : rem;
        res_d = bus.W64M ? XLEN'($signed(sel[31:0])) : sel;
    end
    // W-stage result register; flush takes priority over stall
    always_ff @(posedge clk) begin
        if (reset || bus.FlushW) res_q <= '0;
        else if (!bus.StallW) res_q <= res_d;
    end
    assign bus.MDUResultW = res_q;
endmodule
